cpu_irq_responder: RTL and testbench

//  Core-side end of the interrupt request/acknowledge handshake. It accepts int_req/int_id/int_vector

---
 rtl/cpu_irq_responder.sv | 195 +++++++++++++++++++
 tb/tb_cpu_irq_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_irq_responder.sv
// Core-side interrupt responder: waits for an instruction boundary, saves the return PC,
// redirects fetch to the ISR, acknowledges the controller and restores state on eret.
module cpu_irq_responder #(
   parameter int                NUM_IRQS = 16,
   parameter int                ID_W     = $clog2(NUM_IRQS),
   parameter int                PC_W     = 32,
   parameter logic [PC_W-1:0]   VEC_BASE = 32'h0000_0100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              int_req,
   input  logic [ID_W-1:0]   int_id,
   input  logic [7:0]        int_vector,
   output logic              ack,
   input  logic              gie_set,
   input  logic              gie_clr,
   output logic              gie,
   input  logic              boundary,
   input  logic [PC_W-1:0]   cur_pc,
   output logic              stall_req,
   output logic              redirect,
   output logic [PC_W-1:0]   redirect_pc,
   input  logic              eret,
   output logic              in_isr,
   output logic [ID_W-1:0]   cur_id,
   output logic [PC_W-1:0]   epc,
   output logic [15:0]       lat_last
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT     = 3'd1;
   localparam logic [2:0] S_REDIRECT = 3'd2;
   localparam logic [2:0] S_ACK      = 3'd3;
   localparam logic [2:0] S_ISR      = 3'd4;
   localparam logic [2:0] S_RETURN   = 3'd5;

   logic [2:0]       r_state;
   logic             r_gie;
   logic             r_saved_gie;
   logic [15:0]      r_lat_cnt;
   logic [15:0]      r_lat_last;
   logic [PC_W-1:0]  r_epc;
   logic [PC_W-1:0]  r_redirect_pc;
   logic [ID_W-1:0]  r_cur_id;
   logic             r_ack;
   logic             r_stall;
   logic             r_redirect;
   logic             r_in_isr;

   logic [2:0]       w_state_nxt;
   logic             w_gie_nxt;
   logic             w_saved_gie_nxt;
   logic [15:0]      w_lat_cnt_nxt;
   logic [15:0]      w_lat_inc;
   logic [PC_W-1:0]  w_vec_pc;
   logic             w_take;
   logic             w_ret;

   // Clear beats set when both CSR writes land in the same cycle.
   function automatic logic csr_apply(input logic cur, input logic set, input logic clr);
      if (clr) begin
         return 1'b0;
      end else if (set) begin
         return 1'b1;
      end else begin
         return cur;
      end
   endfunction

   assign w_lat_inc = (r_lat_cnt == 16'hFFFF) ? 16'hFFFF : (r_lat_cnt + 16'd1);
   assign w_vec_pc  = VEC_BASE + {{(PC_W-8){1'b0}}, int_vector};

   // Next-state, global-enable and latency-counter decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_gie_nxt       = r_gie;
      w_saved_gie_nxt = r_saved_gie;
      w_lat_cnt_nxt   = r_lat_cnt;
      w_take          = 1'b0;
      w_ret           = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_gie_nxt = csr_apply(r_gie, gie_set, gie_clr);
            if (int_req && r_gie) begin
               w_state_nxt   = S_WAIT;
               w_lat_cnt_nxt = 16'd0;
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end
         S_WAIT: begin
            w_lat_cnt_nxt = w_lat_inc;
            if (gie_clr || !int_req) begin
               w_state_nxt = S_IDLE;
               w_gie_nxt   = csr_apply(r_gie, gie_set, gie_clr);
            end else if (boundary) begin
               w_state_nxt     = S_REDIRECT;
               w_take          = 1'b1;
               w_saved_gie_nxt = csr_apply(r_gie, gie_set, gie_clr);
               w_gie_nxt       = 1'b0;
            end else begin
               w_gie_nxt   = csr_apply(r_gie, gie_set, gie_clr);
            end
         end
         // While servicing, CSR writes target the value restored on return.
         S_REDIRECT: begin
            w_state_nxt     = S_ACK;
            w_saved_gie_nxt = csr_apply(r_saved_gie, gie_set, gie_clr);
            w_gie_nxt       = 1'b0;
         end
         S_ACK: begin
            w_state_nxt     = S_ISR;
            w_saved_gie_nxt = csr_apply(r_saved_gie, gie_set, gie_clr);
            w_gie_nxt       = 1'b0;
         end
         S_ISR: begin
            w_saved_gie_nxt = csr_apply(r_saved_gie, gie_set, gie_clr);
            w_gie_nxt       = 1'b0;
            if (eret) begin
               w_state_nxt = S_RETURN;
               w_ret       = 1'b1;
            end else begin
               w_state_nxt = S_ISR;
            end
         end
         S_RETURN: begin
            w_state_nxt = S_IDLE;
            w_gie_nxt   = csr_apply(r_saved_gie, gie_set, gie_clr);
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gie_nxt   = 1'b0;
         end
      endcase
   end

   // State, enable and latency registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_gie       <= 1'b0;
         r_saved_gie <= 1'b0;
         r_lat_cnt   <= 16'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_gie       <= w_gie_nxt;
         r_saved_gie <= w_saved_gie_nxt;
         r_lat_cnt   <= w_lat_cnt_nxt;
      end
   end

   // Captured context: written on take, redirect target reloaded on eret, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_epc         <= {PC_W{1'b0}};
         r_cur_id      <= {ID_W{1'b0}};
         r_redirect_pc <= {PC_W{1'b0}};
         r_lat_last    <= 16'd0;
      end else if (w_take) begin
         r_epc         <= cur_pc;
         r_cur_id      <= int_id;
         r_redirect_pc <= w_vec_pc;
         r_lat_last    <= w_lat_inc;
      end else if (w_ret) begin
         r_redirect_pc <= r_epc;
      end
   end

   // Strobes registered from the next state so they align with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack      <= 1'b0;
         r_stall    <= 1'b0;
         r_redirect <= 1'b0;
         r_in_isr   <= 1'b0;
      end else begin
         r_ack      <= (w_state_nxt == S_ACK);
         r_stall    <= (w_state_nxt == S_WAIT);
         r_redirect <= (w_state_nxt == S_REDIRECT) || (w_state_nxt == S_RETURN);
         r_in_isr   <= (w_state_nxt == S_REDIRECT) || (w_state_nxt == S_ACK) ||
                       (w_state_nxt == S_ISR)      || (w_state_nxt == S_RETURN);
      end
   end

   assign ack         = r_ack;
   assign gie         = r_gie;
   assign stall_req   = r_stall;
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign in_isr      = r_in_isr;
   assign cur_id      = r_cur_id;
   assign epc         = r_epc;
   assign lat_last    = r_lat_last;

endmodule

// File: tb/tb_cpu_irq_responder.sv
// Bench for cpu_irq_responder: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level reference model.
module tb_cpu_irq_responder;

   localparam int          ID_W     = 4;
   localparam int          PC_W     = 32;
   localparam logic [31:0] VEC_BASE = 32'h0000_0100;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             int_req = 1'b0;
   logic [ID_W-1:0]  int_id = 4'd0;
   logic [7:0]       int_vector = 8'd0;
   logic             ack;
   logic             gie_set = 1'b0;
   logic             gie_clr = 1'b0;
   logic             gie;
   logic             boundary = 1'b0;
   logic [PC_W-1:0]  cur_pc = 32'd0;
   logic             stall_req;
   logic             redirect;
   logic [PC_W-1:0]  redirect_pc;
   logic             eret = 1'b0;
   logic             in_isr;
   logic [ID_W-1:0]  cur_id;
   logic [PC_W-1:0]  epc;
   logic [15:0]      lat_last;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_irq_responder #(.NUM_IRQS(16), .ID_W(ID_W), .PC_W(PC_W), .VEC_BASE(VEC_BASE)) dut (
      .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_id(int_id), .int_vector(int_vector),
      .ack(ack), .gie_set(gie_set), .gie_clr(gie_clr), .gie(gie), .boundary(boundary),
      .cur_pc(cur_pc), .stall_req(stall_req), .redirect(redirect), .redirect_pc(redirect_pc),
      .eret(eret), .in_isr(in_isr), .cur_id(cur_id), .epc(epc), .lat_last(lat_last)
   );

   always #5 clk = ~clk;

   // Reference model: waiting flag, service age since take, return-cycle flag.
   logic        m_gie, m_saved, m_waiting, m_in_svc, m_ret;
   int          m_age, m_wait;
   logic [31:0] m_epc, m_rpc;
   logic [3:0]  m_id;
   logic [15:0] m_lat;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic csr(input logic cur);
      return gie_clr ? 1'b0 : (gie_set ? 1'b1 : cur);
   endfunction

   task automatic model_reset();
      m_gie = 1'b0; m_saved = 1'b0; m_waiting = 1'b0; m_in_svc = 1'b0; m_ret = 1'b0;
      m_age = 0; m_wait = 0; m_epc = 32'd0; m_rpc = 32'd0; m_id = 4'd0; m_lat = 16'd0;
   endtask

   task automatic model_step();
      if (m_ret) begin
         m_ret = 1'b0;
         m_gie = csr(m_saved);
      end else if (m_in_svc) begin
         m_saved = csr(m_saved);
         if (m_age >= 3 && eret) begin
            m_in_svc = 1'b0; m_ret = 1'b1; m_rpc = m_epc;
         end else if (m_age < 3) begin
            m_age++;
         end
      end else if (m_waiting) begin
         if (m_wait < 65535) m_wait++;
         if (gie_clr || !int_req) begin
            m_waiting = 1'b0; m_gie = csr(m_gie);
         end else if (boundary) begin
            m_epc = cur_pc; m_id = int_id; m_rpc = VEC_BASE + {24'd0, int_vector};
            m_lat = 16'(m_wait); m_saved = csr(m_gie); m_gie = 1'b0;
            m_waiting = 1'b0; m_in_svc = 1'b1; m_age = 1;
         end else begin
            m_gie = csr(m_gie);
         end
      end else begin
         if (int_req && m_gie) begin
            m_waiting = 1'b1; m_wait = 0;
         end
         m_gie = csr(m_gie);
      end
   endtask

   task automatic check_outputs();
      check_val("stall_req",   32'(stall_req),   32'(m_waiting));
      check_val("redirect",    32'(redirect),    32'((m_in_svc && m_age == 1) || m_ret));
      check_val("ack",         32'(ack),         32'(m_in_svc && m_age == 2));
      check_val("in_isr",      32'(in_isr),      32'(m_in_svc || m_ret));
      check_val("gie",         32'(gie),         32'(m_gie));
      check_val("epc",         epc,              m_epc);
      check_val("redirect_pc", redirect_pc,      m_rpc);
      check_val("cur_id",      32'(cur_id),      32'(m_id));
      check_val("lat_last",    32'(lat_last),    32'(m_lat));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   // Run n cycles, counting strobes; the controller drops int_req once it sees ack.
   task automatic run_count(input int n, output int stalls, output int acks, output int redirs);
      stalls = 0; acks = 0; redirs = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         stalls += int'(stall_req);
         redirs += int'(redirect);
         if (ack) begin
            acks++;
            int_req = 1'b0;
         end
      end
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      check_val({tag, "_ack"},    32'(ack),       32'd0);
      check_val({tag, "_in_isr"}, 32'(in_isr),    32'd0);
      check_val({tag, "_gie"},    32'(gie),       32'd0);
      check_val({tag, "_epc"},    epc,            32'd0);
      check_val({tag, "_rpc"},    redirect_pc,    32'd0);
      check_val({tag, "_redir"},  32'(redirect),  32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_inputs();
      int_req = 1'b0; gie_set = 1'b0; gie_clr = 1'b0; boundary = 1'b0; eret = 1'b0;
   endtask

   int st, ak, rd;

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // 1: minimum latency take
      gie_set = 1'b1; cycle(); gie_set = 1'b0;
      int_req = 1'b1; int_id = 4'd3; int_vector = 8'h18; boundary = 1'b1; cur_pc = 32'h0000_2040;
      cycle();
      check_val("t1_stall", 32'(stall_req), 32'd1);
      cycle();
      check_val("t1_redirect", 32'(redirect), 32'd1);
      check_val("t1_rpc", redirect_pc, 32'h0000_0118);
      cycle();
      check_val("t1_ack", 32'(ack), 32'd1);
      check_val("t1_epc", epc, 32'h0000_2040);
      check_val("t1_id", 32'(cur_id), 32'd3);
      check_val("t1_lat", 32'(lat_last), 32'd1);
      int_req = 1'b0;
      cycle(); cycle();

      // 4: eret returns to the saved PC and restores gie
      eret = 1'b1; cycle(); eret = 1'b0;
      check_val("t4_redirect", 32'(redirect), 32'd1);
      check_val("t4_rpc", redirect_pc, 32'h0000_2040);
      check_val("t4_in_isr", 32'(in_isr), 32'd1);
      cycle();
      check_val("t4_in_isr_drop", 32'(in_isr), 32'd0);
      check_val("t4_gie", 32'(gie), 32'd1);

      // 2: masked request is never taken until gie_set
      gie_clr = 1'b1; cycle(); gie_clr = 1'b0;
      int_req = 1'b1; int_id = 4'd7; int_vector = 8'h22; boundary = 1'b1;
      run_count(20, st, ak, rd);
      check_val("t2_masked_stall", 32'(st), 32'd0);
      check_val("t2_masked_ack", 32'(ak), 32'd0);
      check_val("t2_masked_redir", 32'(rd), 32'd0);
      gie_set = 1'b1; cycle(); gie_set = 1'b0;
      run_count(4, st, ak, rd);
      check_val("t2_taken_ack", 32'(ak), 32'd1);
      eret = 1'b1; cycle(); eret = 1'b0; cycle();

      // 3: five boundary-free WAIT cycles
      cur_pc = 32'h0000_3000; int_req = 1'b1; int_id = 4'd9; int_vector = 8'h30; boundary = 1'b0;
      run_count(6, st, ak, rd);
      boundary = 1'b1;
      begin
         int st2, ak2, rd2;
         run_count(4, st2, ak2, rd2);
         check_val("t3_stall_cycles", 32'(st + st2), 32'd6);
         check_val("t3_acks", 32'(ak + ak2), 32'd1);
      end
      check_val("t3_lat", 32'(lat_last), 32'd6);
      eret = 1'b1; cycle(); eret = 1'b0; cycle();

      // 5: abandon WAIT with simultaneous set/clr, then stray eret in IDLE
      int_req = 1'b1; boundary = 1'b0; cycle();
      check_val("t5_wait", 32'(stall_req), 32'd1);
      gie_set = 1'b1; gie_clr = 1'b1; cycle(); gie_set = 1'b0; gie_clr = 1'b0;
      check_val("t5_stall_drop", 32'(stall_req), 32'd0);
      check_val("t5_gie", 32'(gie), 32'd0);
      eret = 1'b1; boundary = 1'b1; cycle(); eret = 1'b0;
      check_val("t5_eret_idle", 32'(redirect), 32'd0);
      run_count(5, st, ak, rd);
      check_val("t5_no_ack", 32'(ak), 32'd0);
      clear_inputs();

      // 6: reset during ACK and during ISR
      gie_set = 1'b1; cycle(); gie_set = 1'b0;
      int_req = 1'b1; int_id = 4'd5; int_vector = 8'h40; boundary = 1'b1; cur_pc = 32'h0000_5000;
      cycle(); cycle(); cycle();
      check_val("t6_in_ack", 32'(ack), 32'd1);
      async_reset("t6_rst_ack");
      int_req = 1'b0;
      run_count(5, st, ak, rd);
      check_val("t6_no_ack", 32'(ak), 32'd0);
      gie_set = 1'b1; cycle(); gie_set = 1'b0;
      int_req = 1'b1;
      run_count(5, st, ak, rd);
      check_val("t6_fresh_ack", 32'(ak), 32'd1);
      async_reset("t6_rst_isr");
      run_count(5, st, ak, rd);
      check_val("t6_no_ack2", 32'(ak), 32'd0);

      // Random traffic
      clear_inputs();
      for (int i = 0; i < 4000; i++) begin
         gie_set  = ($urandom_range(0, 4) == 0);
         gie_clr  = ($urandom_range(0, 11) == 0);
         boundary = ($urandom_range(0, 1) == 1);
         eret     = ($urandom_range(0, 3) == 0);
         cur_pc   = $urandom;
         if (!int_req && $urandom_range(0, 5) == 0) begin
            int_req    = 1'b1;
            int_id     = 4'($urandom);
            int_vector = 8'($urandom);
         end else if (int_req && $urandom_range(0, 39) == 0) begin
            int_req = 1'b0;
         end
         cycle();
         if (ack) int_req = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
